// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: load opcodes and write-back FSM state encoding shared by the WB stage files.
package wb_stage_pkg;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;

    typedef enum logic [1:0] {
        WB_EMPTY     = 2'd0,
        WB_COMMIT    = 2'd1,
        WB_WAIT_LOAD = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM/WB entry, data-memory response and register-bank write port of the WB stage.
interface wb_stage_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  i_valid;
    logic                  i_reg_write;
    logic                  i_mem_to_reg;
    logic [REG_ADDR_W-1:0] i_write_register;
    logic [DATA_W-1:0]     i_alu_result;
    logic [5:0]            i_opcode;
    logic [1:0]            i_addr_lo;
    logic [DATA_W-1:0]     i_mem_rdata;
    logic                  i_mem_rvalid;
    logic                  o_ready;
    logic                  o_stall_pipe;
    logic                  o_reg_write;
    logic [REG_ADDR_W-1:0] o_write_register;
    logic [DATA_W-1:0]     o_write_data;

    modport master (
        output i_valid, i_reg_write, i_mem_to_reg, i_write_register, i_alu_result,
               i_opcode, i_addr_lo, i_mem_rdata, i_mem_rvalid,
        input  o_ready, o_stall_pipe, o_reg_write, o_write_register, o_write_data
    );

    modport slave (
        input  i_valid, i_reg_write, i_mem_to_reg, i_write_register, i_alu_result,
               i_opcode, i_addr_lo, i_mem_rdata, i_mem_rvalid,
        output o_ready, o_stall_pipe, o_reg_write, o_write_register, o_write_data
    );

endinterface

// File: rtl/wb_load_formatter.sv
// wb_load_formatter: selects and extends the loaded byte/half/word by opcode and address low bits.
module wb_load_formatter
    import wb_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [5:0]  opcode_i,
    input  logic [1:0]  addr_lo_i,
    output logic [31:0] word_o
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b = rdata_i[8*addr_lo_i +: 8];
        h = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (opcode_i)
            OP_LB:   word_o = {{24{b[7]}}, b};
            OP_LBU:  word_o = {24'b0, b};
            OP_LH:   word_o = {{16{h[15]}}, h};
            OP_LHU:  word_o = {16'b0, h};
            OP_LW:   word_o = rdata_i;
            default: word_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: MIPS write-back stage; holds the MEM/WB entry, waits for load data, drives the register-bank write port.
// Define WB_SUBWORD_LOAD_EN to format load data by opcode (LB/LBU/LH/LHU); otherwise loads write the full word.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input logic        clk,
    input logic        reset,
    wb_stage_if.slave  bus
);

    wb_state_e             state_q, state_d;
    logic                  rw_q, rw_d;
    logic [REG_ADDR_W-1:0] wreg_q, wreg_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     load_word;
    logic                  capture;
    logic                  load_done;

`ifdef WB_SUBWORD_LOAD_EN
    logic [5:0] op_q;
    logic [1:0] lo_q;

    // Load width/offset must survive until the response arrives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q <= '0;
            lo_q <= '0;
        end else if (capture) begin
            op_q <= bus.i_opcode;
            lo_q <= bus.i_addr_lo;
        end
    end

    wb_load_formatter u_fmt (
        .rdata_i  (bus.i_mem_rdata),
        .opcode_i (op_q),
        .addr_lo_i(lo_q),
        .word_o   (load_word)
    );
`else
    logic unused_subword;
    assign unused_subword = ^{bus.i_opcode, bus.i_addr_lo};
    assign load_word      = bus.i_mem_rdata;
`endif

    assign bus.o_ready          = state_q != WB_WAIT_LOAD;
    assign bus.o_stall_pipe     = ~bus.o_ready;
    assign bus.o_reg_write      = (state_q == WB_COMMIT) & rw_q & (|wreg_q);
    assign bus.o_write_register = wreg_q;
    assign bus.o_write_data     = wdata_q;

    always_comb begin
        capture   = bus.i_valid & bus.o_ready;
        load_done = (state_q == WB_WAIT_LOAD) & bus.i_mem_rvalid;
        state_d   = (state_q == WB_WAIT_LOAD) ? (bus.i_mem_rvalid ? WB_COMMIT : WB_WAIT_LOAD)
                  : capture ? (bus.i_mem_to_reg ? WB_WAIT_LOAD : WB_COMMIT)
                  : WB_EMPTY;
        rw_d      = capture ? bus.i_reg_write : rw_q;
        wreg_d    = capture ? bus.i_write_register : wreg_q;
        wdata_d   = load_done ? load_word
                  : (capture & ~bus.i_mem_to_reg) ? bus.i_alu_result
                  : wdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= WB_EMPTY;
            rw_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
        end
    end

endmodule
